change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter AMT_W, default 10: width of cent amounts.
REQ-002 SHALL have parameter GAP_CYCLES, default 3: idle cycles after each coin pulse (ejector recovery); legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: request to pay out amount; sampled only in IDLE.
REQ-006 SHALL have port amount, input, AMT_W: change to pay, in cents; captured with start.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port coin_dollar, output, 1: one-cycle eject pulse for a 100c coin.
REQ-009 SHALL have port coin_quarter, output, 1: one-cycle eject pulse for a 25c coin.
REQ-010 SHALL have port coin_dime, output, 1: one-cycle eject pulse for a 10c coin.
REQ-011 SHALL have port coin_nickel, output, 1: one-cycle eject pulse for a 5c coin.
REQ-012 SHALL have port remaining, output, AMT_W: cents still owed; feeds the change display.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when payout ends.
REQ-014 SHALL have port short, output, 1: valid with done; high if the residual was 1..4c and could not be paid.

Function
REQ-015 SHALL implement the states IDLE, SELECT, PULSE, GAP and DONE.
REQ-016 IDLE with start=1 SHALL load remaining<=amount and go to SELECT; start=0 SHALL hold IDLE.
REQ-017 SELECT SHALL pick the largest coin value <= remaining using greedy order 100, 25, 10, 5; if remaining<5, SHALL go to DONE; otherwise SHALL go to PULSE.
REQ-018 PULSE SHALL assert exactly one coin output for one cycle, subtract its value from remaining at the end of that cycle, and go to GAP.
REQ-019 GAP SHALL hold all coin outputs low for GAP_CYCLES cycles, then go to SELECT.
REQ-020 DONE SHALL assert done for one cycle, set short=(remaining!=0), and return to IDLE; remaining SHALL hold its residual until the next start.
REQ-021 Timing: with start sampled at edge 0, coin n SHALL pulse in cycle 2+(n-1)(GAP_CYCLES+2), and done SHALL pulse 2 cycles after the last GAP ends (1 SELECT + DONE).
REQ-022 amount=0 SHALL produce no coins, with done in cycle 2 and short=0.
REQ-023 start while busy SHALL be ignored; amount changes while busy SHALL have no effect.
REQ-024 At most one coin output SHALL be high in any cycle; coin outputs and done SHALL never be high together.
REQ-025 Subtraction SHALL never underflow; remaining SHALL be monotonically non-increasing during a payout.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE; busy, all coin outputs, done and short SHALL be 0, remaining SHALL be 0, and the gap counter SHALL be 0.
REQ-027 rst SHALL take priority over start and SHALL abort a payout mid-sequence with no further coin pulses and no done.
REQ-028 The first start SHALL be honoured at the first edge after rst deasserts.

Structure
REQ-029 Coin values (100, 25, 10, 5) and the state encodings SHALL live in the shared vending constants package used by the vending machine controller.
REQ-030 The greedy coin choice SHALL be a combinational sub-module coin_select (input remaining; outputs one-hot coin and value).
REQ-031 The gap counter SHALL be 4 bits wide; the RTL SHALL stay within 120-400 lines.

Verification (GAP_CYCLES=3)
REQ-032 start, amount=65 -> quarter@2, quarter@7, dime@12, nickel@17, done@22, short=0, remaining=0.
REQ-033 start, amount=137 -> dollar, quarter, dime; done with short=1 and remaining=2.
REQ-034 start, amount=0 -> no coin pulses, done@2, short=0, busy high for cycles 1-2 only.
REQ-035 start, amount=250, plus a second start with amount=5 at cycle 4 -> second start ignored; output is dollar, dollar, quarter, quarter.
REQ-036 start, amount=300, then rst at cycle 9 -> exactly two dollar pulses, then all outputs 0 and no done; a new start with amount=10 then yields a single dime.
REQ-037 All scenarios: a checker SHALL assert a one-hot-or-zero coin bus and confirm the sum of ejected coins plus the residual equals amount.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg
//   Shared vending constants: coin denominations in cents, the one-hot coin
//   bundle type, gap counter width and the change dispenser state encoding.
//   Imported by coin_select and change_dispenser.
package change_dispenser_pkg;

    // Coin denominations in cents, largest first (greedy order).
    localparam int unsigned CENTS_DOLLAR  = 100;
    localparam int unsigned CENTS_QUARTER = 25;
    localparam int unsigned CENTS_DIME    = 10;
    localparam int unsigned CENTS_NICKEL  = 5;

    // Width of the post-pulse ejector recovery counter.
    localparam int unsigned GAP_CNT_W = 4;

    // One-hot (or all-zero) coin selection bundle.
    typedef struct packed {
        logic dollar;
        logic quarter;
        logic dime;
        logic nickel;
    } coin_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if
//   Payout request / coin ejector bundle for the change dispenser.
//   start, amount        : payout request (master -> slave)
//   busy                 : dispenser not idle
//   coin_dollar..nickel  : one-cycle eject pulses
//   remaining            : cents still owed (change display)
//   done, short          : end-of-payout pulse, unpaid 1..4c residual flag
//   modport slave  : dispenser side
//   modport master : requester / display side
interface change_dispenser_if #(
    parameter int unsigned AMT_W = 10
) ();

    logic             start;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             coin_dollar;
    logic             coin_quarter;
    logic             coin_dime;
    logic             coin_nickel;
    logic [AMT_W-1:0] remaining;
    logic             done;
    logic             short;

    modport slave (
        input  start,
        input  amount,
        output busy,
        output coin_dollar,
        output coin_quarter,
        output coin_dime,
        output coin_nickel,
        output remaining,
        output done,
        output short
    );

    modport master (
        output start,
        output amount,
        input  busy,
        input  coin_dollar,
        input  coin_quarter,
        input  coin_dime,
        input  coin_nickel,
        input  remaining,
        input  done,
        input  short
    );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// coin_select
//   Combinational greedy coin choice: the largest denomination that does not
//   exceed the amount still owed. All-zero outputs when less than a nickel
//   remains.
//   remaining : cents still owed
//   coin      : one-hot chosen coin (or zero)
//   value     : cents value of the chosen coin (or zero)
module coin_select
    import change_dispenser_pkg::*;
#(
    parameter int unsigned AMT_W = 10
) (
    input  logic [AMT_W-1:0] remaining,
    output coin_t            coin,
    output logic [AMT_W-1:0] value
);

    localparam logic [AMT_W-1:0] V_DOLLAR  = AMT_W'(CENTS_DOLLAR);
    localparam logic [AMT_W-1:0] V_QUARTER = AMT_W'(CENTS_QUARTER);
    localparam logic [AMT_W-1:0] V_DIME    = AMT_W'(CENTS_DIME);
    localparam logic [AMT_W-1:0] V_NICKEL  = AMT_W'(CENTS_NICKEL);

    always_comb begin
        coin  = '0;
        value = '0;
        if (remaining >= V_DOLLAR) begin
            coin.dollar = 1'b1;
            value       = V_DOLLAR;
        end else if (remaining >= V_QUARTER) begin
            coin.quarter = 1'b1;
            value        = V_QUARTER;
        end else if (remaining >= V_DIME) begin
            coin.dime = 1'b1;
            value     = V_DIME;
        end else if (remaining >= V_NICKEL) begin
            coin.nickel = 1'b1;
            value       = V_NICKEL;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out an amount in cents as a sequence of single-coin eject pulses,
//   greedy largest-coin-first, with GAP_CYCLES idle cycles after every pulse
//   for ejector recovery. Ends with a one-cycle done pulse; short flags an
//   unpayable 1..4c residual, which stays on remaining until the next start.
//   clk, rst : clock, synchronous active-high reset
//   bus      : change_dispenser_if slave (start/amount in; busy, coin pulses,
//              remaining, done, short out)
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned AMT_W      = 10,
    parameter int unsigned GAP_CYCLES = 3
) (
    input logic                clk,
    input logic                rst,
    change_dispenser_if.slave  bus
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [AMT_W-1:0]       remaining_q, remaining_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    coin_t                  sel_coin;
    logic [AMT_W-1:0]       sel_value;

    // remaining_q is unchanged between SELECT and PULSE, so the same
    // combinational choice drives both the branch and the ejected coin.
    coin_select #(
        .AMT_W (AMT_W)
    ) u_coin_select (
        .remaining (remaining_q),
        .coin      (sel_coin),
        .value     (sel_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.amount;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (sel_coin == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                // sel_value <= remaining_q by construction: cannot underflow.
                remaining_d = remaining_q - sel_value;
                gap_cnt_d   = GAP_LOAD;
                state_d     = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_SELECT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy         = (state_q != ST_IDLE);
        bus.coin_dollar  = (state_q == ST_PULSE) && sel_coin.dollar;
        bus.coin_quarter = (state_q == ST_PULSE) && sel_coin.quarter;
        bus.coin_dime    = (state_q == ST_PULSE) && sel_coin.dime;
        bus.coin_nickel  = (state_q == ST_PULSE) && sel_coin.nickel;
        bus.remaining    = remaining_q;
        bus.done         = (state_q == ST_DONE);
        bus.short        = (state_q == ST_DONE) && (remaining_q != '0);
    end

endmodule
